triangle_setup: RTL
===================

# triangle_setup

Per-frame triangle setup stage between `vertex_shader` and `rasterizer`. On a `start` pulse (driven from frame start / vsync) it captures the three screen-space vertices and sequentially computes the three edge-function coefficient sets and the doubled signed area, using one shared multiplier. It normalizes winding so that "inside" is always all edges ≥ 0, then commits all results atomically to output registers. The rasterizer can then evaluate edges incrementally instead of recomputing cross products every pixel.

## Interface
- `COORD_W`, default 10: vertex coordinate width, unsigned.
- `clk_pix`, in, 1: pixel clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: one-cycle request; sampled only in IDLE.
- `ax, ay, bx, by, cx, cy`, in, 10 each: vertex coordinates, unsigned.
- `ea0, ea1, ea2`, out, 11 each: signed x-coefficients A_i.
- `eb0, eb1, eb2`, out, 11 each: signed y-coefficients B_i.
- `ec0, ec1, ec2`, out, 21 each: signed constants C_i.
- `area`, out, 21: signed doubled area after normalization, always ≥ 0.
- `flipped`, out, 1: input winding was negative and results were negated.
- `degenerate`, out, 1: area == 0.
- `busy`, out, 1: high from the cycle after start acceptance until commit.
- `done`, out, 1: one-cycle pulse on the cycle the outputs update.

## Operation
- Edges: E0 runs B→C, E1 runs C→A, E2 runs A→B. For edge i from P=(px,py) to Q=(qx,qy): A_i = py−qy, B_i = qx−px, C_i = px·qy − qx·py. E_i(x,y) = A_i·x + B_i·y + C_i.
- area = C0 + C1 + C2, which equals E0(ax,ay). It is accumulated at 23 bits and is exact in 21 bits because |area| ≤ 1023².
- FSM states: IDLE → MUL → SUM → COMMIT → IDLE.
- IDLE: when `start`=1, latch all six vertices, clear the product index, and go to MUL.
- MUL: six cycles, index 0..5. Each cycle registers one unsigned 10×10 → 20-bit product, in order bx·cy, cx·by, cx·ay, ax·cy, ax·by, bx·ay.
- SUM: form the C_i as 21-bit signed differences of product pairs and the A_i/B_i as 11-bit signed differences. Accumulate `area`.
- COMMIT: if area < 0, negate every A_i, B_i, C_i and area, and set `flipped`=1. Set `degenerate` = (area==0). Load all output registers in the same edge and pulse `done`.
- Between commits, outputs hold their previous values, so the rasterizer never sees a partial update.
- `start` asserted outside IDLE is ignored. There is no queueing.
- Vertex inputs may change freely after the acceptance edge, since only the latched copies are used.
- A degenerate triangle still commits. Its coefficients are unnormalized (`flipped`=0) and the consumer treats it as invisible.

## Timing
- Reset values: all coefficient outputs, `area`, `flipped`, `degenerate`, `busy`, `done` = 0. FSM = IDLE.
- `rst` asserted mid-computation: return immediately to IDLE and zero all outputs. No commit occurs.
- Latency: `start` sampled at edge 0. MUL occupies edges 1–6, SUM edge 7, COMMIT edge 8. `done` is high during the cycle after edge 8.
- `busy` is high from after edge 0 through the cycle containing the COMMIT edge.
- A new `start` is accepted no earlier than edge 9, giving a throughput of one triangle per 9 cycles. This is far inside one 480p60 frame.
- `done` and `start` may be high in the same cycle. The FSM is in IDLE then, so the new request is accepted.

## Structure
- Shared package `raster_pkg` holds `COORD_W`=10, `EDGE_AB_W`=11, `EDGE_C_W`=21, `AREA_ACC_W`=23, and the FSM state enum.
- Single module, no sub-module. The lone multiplier is inferred inline, with a 3-bit operand-select mux driven by the product index.

## Test plan
- A(100,100) B(200,100) C(100,200), pulse `start` → after 9 cycles `done`=1. Expect A=(−100,100,0), B=(−100,0,100), C=(30000,−10000,−10000), area=10000, flipped=0, degenerate=0.
- Same triangle with B and C swapped → area=10000, flipped=1, and every coefficient equals the negation of the raw (clockwise) values.
- Collinear (0,0),(10,10),(20,20) → area=0, degenerate=1, done pulses.
- Extreme (0,0),(1023,0),(0,1023) → area=1046529 with no overflow. Also check C values for the (1023,1023) corner sign cases.
- `start` re-pulsed at cycles 3 and 8 → both ignored; exactly one `done`. A pulse in the `done` cycle is accepted.
- `rst` asserted at MUL index 3 → all outputs 0 immediately, no `done`. A subsequent `start` produces correct results.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared raster-pipeline definitions: coordinate/coefficient widths and the
// triangle-setup sequencing states.
package raster_pkg;

    localparam int COORD_W    = 10;
    localparam int EDGE_AB_W  = 11;
    localparam int EDGE_C_W   = 21;
    localparam int AREA_ACC_W = 23;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_SUM,
        ST_COMMIT
    } state_t;

endpackage

// File: rtl/triangle_setup.sv
// Per-frame triangle setup: edge-function coefficients and doubled area from
// three latched vertices, using one shared multiplier, committed atomically.
module triangle_setup
    import raster_pkg::*;
#(
    parameter int COORD_W = raster_pkg::COORD_W
) (
    input  logic                 clk_pix,
    input  logic                 rst,
    input  logic                 start,
    input  logic [COORD_W-1:0]   ax,
    input  logic [COORD_W-1:0]   ay,
    input  logic [COORD_W-1:0]   bx,
    input  logic [COORD_W-1:0]   by,
    input  logic [COORD_W-1:0]   cx,
    input  logic [COORD_W-1:0]   cy,
    output logic [COORD_W:0]     ea0,
    output logic [COORD_W:0]     ea1,
    output logic [COORD_W:0]     ea2,
    output logic [COORD_W:0]     eb0,
    output logic [COORD_W:0]     eb1,
    output logic [COORD_W:0]     eb2,
    output logic [2*COORD_W:0]   ec0,
    output logic [2*COORD_W:0]   ec1,
    output logic [2*COORD_W:0]   ec2,
    output logic [2*COORD_W:0]   area,
    output logic                 flipped,
    output logic                 degenerate,
    output logic                 busy,
    output logic                 done
);

    localparam int AB_W  = COORD_W + 1;
    localparam int P_W   = 2 * COORD_W;
    localparam int C_W   = P_W + 1;
    localparam int ACC_W = C_W + 2;

    state_t r_state;
    state_t w_next;

    logic [2:0]                r_idx;
    logic [COORD_W-1:0]        r_ax, r_ay, r_bx, r_by, r_cx, r_cy;
    logic [P_W-1:0]            r_prod [6];
    logic signed [AB_W-1:0]    r_ea [3];
    logic signed [AB_W-1:0]    r_eb [3];
    logic signed [C_W-1:0]     r_ec [3];
    logic signed [ACC_W-1:0]   r_acc;

    logic [COORD_W-1:0]        w_op_x, w_op_y;
    logic [P_W-1:0]            w_prod;
    logic signed [AB_W-1:0]    w_ea [3];
    logic signed [AB_W-1:0]    w_eb [3];
    logic signed [C_W-1:0]     w_ec [3];
    logic signed [ACC_W-1:0]   w_acc;
    logic                      w_flip;
    logic signed [AB_W-1:0]    w_ea_n [3];
    logic signed [AB_W-1:0]    w_eb_n [3];
    logic signed [C_W-1:0]     w_ec_n [3];
    logic signed [ACC_W-1:0]   w_area_n;

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge value of every other register, independent of block order.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_MUL;
            ST_MUL:    if (r_idx == 3'd5) w_next = ST_SUM;
            ST_SUM:    w_next = ST_COMMIT;
            ST_COMMIT: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    assign busy = (r_state != ST_IDLE);

    // Product order pairs up as C0 = p0-p1, C1 = p2-p3, C2 = p4-p5.
    always_comb begin
        w_op_x = '0;
        w_op_y = '0;
        case (r_idx)
            3'd0: begin w_op_x = r_bx; w_op_y = r_cy; end
            3'd1: begin w_op_x = r_cx; w_op_y = r_by; end
            3'd2: begin w_op_x = r_cx; w_op_y = r_ay; end
            3'd3: begin w_op_x = r_ax; w_op_y = r_cy; end
            3'd4: begin w_op_x = r_ax; w_op_y = r_by; end
            3'd5: begin w_op_x = r_bx; w_op_y = r_ay; end
            default: ;
        endcase
        w_prod = P_W'(w_op_x) * P_W'(w_op_y);
    end

    always_comb begin
        w_ea[0] = $signed({1'b0, r_by}) - $signed({1'b0, r_cy});
        w_ea[1] = $signed({1'b0, r_cy}) - $signed({1'b0, r_ay});
        w_ea[2] = $signed({1'b0, r_ay}) - $signed({1'b0, r_by});
        w_eb[0] = $signed({1'b0, r_cx}) - $signed({1'b0, r_bx});
        w_eb[1] = $signed({1'b0, r_ax}) - $signed({1'b0, r_cx});
        w_eb[2] = $signed({1'b0, r_bx}) - $signed({1'b0, r_ax});
        for (int i = 0; i < 3; i++) begin
            w_ec[i] = $signed({1'b0, r_prod[2*i]}) - $signed({1'b0, r_prod[2*i+1]});
        end
        w_acc = ACC_W'(w_ec[0]) + ACC_W'(w_ec[1]) + ACC_W'(w_ec[2]);
    end

    // Winding normalisation: negative area means clockwise, so flip all signs.
    always_comb begin
        w_flip = r_acc[ACC_W-1];
        for (int i = 0; i < 3; i++) begin
            w_ea_n[i] = w_flip ? -r_ea[i] : r_ea[i];
            w_eb_n[i] = w_flip ? -r_eb[i] : r_eb[i];
            w_ec_n[i] = w_flip ? -r_ec[i] : r_ec[i];
        end
        w_area_n = w_flip ? -r_acc : r_acc;
    end

    // NOTE: the product scratchpad has no reset; it is always written before
    // it is read, and leaving it out keeps it mappable to plain flops/RAM.
    always_ff @(posedge clk_pix) begin
        if (r_state == ST_MUL) r_prod[r_idx] <= w_prod;
    end

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            r_idx      <= '0;
            r_ax       <= '0; r_ay <= '0;
            r_bx       <= '0; r_by <= '0;
            r_cx       <= '0; r_cy <= '0;
            r_ea       <= '{default: '0};
            r_eb       <= '{default: '0};
            r_ec       <= '{default: '0};
            r_acc      <= '0;
            ea0        <= '0; ea1 <= '0; ea2 <= '0;
            eb0        <= '0; eb1 <= '0; eb2 <= '0;
            ec0        <= '0; ec1 <= '0; ec2 <= '0;
            area       <= '0;
            flipped    <= 1'b0;
            degenerate <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_idx <= '0;
                        r_ax  <= ax; r_ay <= ay;
                        r_bx  <= bx; r_by <= by;
                        r_cx  <= cx; r_cy <= cy;
                    end
                end
                ST_MUL: r_idx <= r_idx + 3'd1;
                ST_SUM: begin
                    r_ea  <= w_ea;
                    r_eb  <= w_eb;
                    r_ec  <= w_ec;
                    r_acc <= w_acc;
                end
                ST_COMMIT: begin
                    ea0        <= w_ea_n[0]; ea1 <= w_ea_n[1]; ea2 <= w_ea_n[2];
                    eb0        <= w_eb_n[0]; eb1 <= w_eb_n[1]; eb2 <= w_eb_n[2];
                    ec0        <= w_ec_n[0]; ec1 <= w_ec_n[1]; ec2 <= w_ec_n[2];
                    area       <= w_area_n[C_W-1:0];
                    flipped    <= w_flip;
                    degenerate <= (r_acc == '0);
                    done       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
